// File: rtl/trace_cfg_pkg.sv
// Shared types for the trace configuration sequencer: FSM states, the
// reserved idle ID and the layout of one buffered firmware-write command.
package trace_cfg_pkg;

    localparam logic [7:0] CFG_IDLE_ID    = 8'hFF;
    localparam int         CFG_MAX_CHAINS = 4;
    localparam int         CFG_CHAIN_W    = $clog2(CFG_MAX_CHAINS);

    typedef enum logic [1:0] {
        TRACE  = 2'd0,
        DRAIN  = 2'd1,
        CONFIG = 2'd2,
        RESUME = 2'd3
    } cfg_state_t;

    typedef struct packed {
        logic [7:0]             configId;
        logic [CFG_CHAIN_W-1:0] chain;
        logic [7:0]             data;
        logic                   last;
    } cfg_entry_t;

endpackage

// File: rtl/cfg_fifo.sv
// Small synchronous FIFO holding queued configuration commands. Depth must be
// a power of two so the read/write pointers wrap naturally.
module cfg_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic i_push,
    input  logic i_pop,
    input  T     i_wdata,
    output T     o_rdata,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_rdata  = r_mem[r_rdPtr];

    // Storage array: written on accepted pushes, contents need no reset
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/trace_config_sequencer.sv
// Buffers host firmware-write commands and, once a batch is committed, takes
// the trace pipeline out of tracing, replays the batch one beat per cycle on
// the broadcast config bus, then returns the pipeline to tracing.
// Optional feature macro CFG_DRAIN_EN: wait for DRAIN_CYCLES quiet cycles of
// trace_valid before leaving tracing.
module trace_config_sequencer
    import trace_cfg_pkg::*;
#(
    parameter int  MAX_CHAINS   = 4,
    parameter int  FIFO_DEPTH   = 8,
    parameter int  DRAIN_CYCLES = 4,
    localparam int CHAIN_W      = $clog2(MAX_CHAINS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_config_id,
    input  logic [CHAIN_W-1:0] cmd_chain,
    input  logic [7:0]         cmd_data,
    input  logic               cmd_last,
    input  logic               trace_valid,
    output logic               tracing,
    output logic [7:0]         configId,
    output logic [7:0]         configData,
    output logic [CHAIN_W-1:0] chainId,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int PW = $clog2(FIFO_DEPTH + 1);

    cfg_state_t         r_state;
    cfg_state_t         w_stateNext;
    logic [PW-1:0]      r_pending;
    logic               r_wasResume;
    logic               r_tracing;
    logic [7:0]         r_configId;
    logic [7:0]         r_configData;
    logic [CHAIN_W-1:0] r_chainId;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    cfg_entry_t         w_pushEntry;
    cfg_entry_t         w_head;
    logic               w_tracingNext;
    logic [7:0]         w_idNext;
    logic [7:0]         w_dataNext;
    logic [CHAIN_W-1:0] w_chainNext;
    logic               w_doneNext;

    assign cmd_ready  = !w_full;
    assign w_push     = cmd_valid && !w_full;
    assign w_pop      = (r_state == CONFIG) && !w_empty;

    assign w_pushEntry.configId = cmd_config_id;
    assign w_pushEntry.chain    = CFG_CHAIN_W'(cmd_chain);
    assign w_pushEntry.data     = cmd_data;
    assign w_pushEntry.last     = cmd_last;

    assign tracing    = r_tracing;
    assign configId   = r_configId;
    assign configData = r_configData;
    assign chainId    = r_chainId;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

    cfg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (cfg_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_pushEntry),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef CFG_DRAIN_EN
    localparam int QW = $clog2(DRAIN_CYCLES + 1);

    logic [QW-1:0] r_quiet;
    logic [QW-1:0] w_quietNext;

    assign w_quietNext = trace_valid ? '0 : (r_quiet + QW'(1));

    // Quiet-cycle counter: only runs while draining, restarts on any traffic
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_quiet <= '0;
        end else if (r_state == DRAIN) begin
            r_quiet <= w_quietNext;
        end else begin
            r_quiet <= '0;
        end
    end
`else
    logic w_unusedDrain;
    assign w_unusedDrain = trace_valid ^ (DRAIN_CYCLES == 0);
`endif

    // Committed-batch counter: +1 on accepting a last entry, -1 on popping one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            case ({w_push && cmd_last, w_pop && w_head.last})
                2'b10:   r_pending <= r_pending + PW'(1);
                2'b01:   r_pending <= r_pending - PW'(1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    // Next state plus the values the registered bus outputs take next edge
    always_comb begin
        w_stateNext   = r_state;
        w_tracingNext = 1'b1;
        w_idNext      = CFG_IDLE_ID;
        w_dataNext    = '0;
        w_chainNext   = '0;
        w_doneNext    = 1'b0;
        case (r_state)
            TRACE: begin
                w_doneNext = r_wasResume;
                if (r_pending != '0) begin
`ifdef CFG_DRAIN_EN
                    w_stateNext = DRAIN;
`else
                    w_stateNext = CONFIG;
`endif
                end
            end
            DRAIN: begin
`ifdef CFG_DRAIN_EN
                if (w_quietNext == QW'(DRAIN_CYCLES)) begin
                    w_stateNext = CONFIG;
                end
`else
                w_stateNext = CONFIG;
`endif
            end
            CONFIG: begin
                w_tracingNext = 1'b0;
                if (w_pop) begin
                    w_idNext    = w_head.configId;
                    w_chainNext = CHAIN_W'(w_head.chain);
                    w_dataNext  = w_head.data;
                    if (w_head.last) begin
                        w_stateNext = RESUME;
                    end
                end
            end
            RESUME: begin
                w_tracingNext = 1'b0;
                w_stateNext   = TRACE;
            end
            default: begin
                w_stateNext = TRACE;
            end
        endcase
    end

    // State register and registered bus/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= TRACE;
            r_wasResume  <= 1'b0;
            r_tracing    <= 1'b1;
            r_configId   <= CFG_IDLE_ID;
            r_configData <= '0;
            r_chainId    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_wasResume  <= (r_state == RESUME);
            r_tracing    <= w_tracingNext;
            r_configId   <= w_idNext;
            r_configData <= w_dataNext;
            r_chainId    <= w_chainNext;
            r_busy       <= (w_stateNext != TRACE);
            r_done       <= w_doneNext;
        end
    end

    // Sticky error: FIFO filled up without any committed batch to drain it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_full && (r_pending == '0)) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_trace_config_sequencer.sv
// Directed testbench for trace_config_sequencer. Honours CFG_DRAIN_EN: with
// the macro defined each pass waits DRAIN_CYCLES extra edges and a dedicated
// drain scenario runs.
module tb_trace_config_sequencer;

    localparam int DRAIN_CYCLES = 4;
`ifdef CFG_DRAIN_EN
    localparam int LAT = DRAIN_CYCLES;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_config_id;
    logic [1:0] cmd_chain;
    logic [7:0] cmd_data;
    logic       cmd_last;
    logic       trace_valid;
    logic       tracing;
    logic [7:0] configId;
    logic [7:0] configData;
    logic [1:0] chainId;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    trace_config_sequencer #(
        .MAX_CHAINS   (4),
        .FIFO_DEPTH   (8),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_config_id (cmd_config_id),
        .cmd_chain     (cmd_chain),
        .cmd_data      (cmd_data),
        .cmd_last      (cmd_last),
        .trace_valid   (trace_valid),
        .tracing       (tracing),
        .configId      (configId),
        .configData    (configData),
        .chainId       (chainId),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] id,
                                 input logic [1:0] ch, input logic [7:0] d,
                                 input logic l);
        cmd_valid     = v;
        cmd_config_id = id;
        cmd_chain     = ch;
        cmd_data      = d;
        cmd_last      = l;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs,
                               input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkBeat(input string tag, input logic [7:0] id,
                             input logic [1:0] ch, input logic [7:0] d);
        checkOutput({tag, "_tracing"}, 16'(tracing), 16'd0);
        checkOutput({tag, "_id"}, 16'(configId), 16'(id));
        checkOutput({tag, "_chain"}, 16'(chainId), 16'(ch));
        checkOutput({tag, "_data"}, 16'(configData), 16'(d));
    endtask

    task automatic checkGuard(input string tag);
        checkOutput({tag, "_tracing"}, 16'(tracing), 16'd0);
        checkOutput({tag, "_id"}, 16'(configId), 16'hFF);
        checkOutput({tag, "_data"}, 16'(configData), 16'd0);
    endtask

    task automatic checkDone(input string tag);
        checkOutput({tag, "_tracing"}, 16'(tracing), 16'd1);
        checkOutput({tag, "_done"}, 16'(done), 16'd1);
        checkOutput({tag, "_id"}, 16'(configId), 16'hFF);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        reset       = 1'b1;
        trace_valid = 1'b0;
        applyStimulus(1'b0, 8'h00, 2'd0, 8'h00, 1'b0);
        step(2);

        $display("[TB] reset values");
        checkOutput("rst_tracing", 16'(tracing), 16'd1);
        checkOutput("rst_id", 16'(configId), 16'hFF);
        checkOutput("rst_data", 16'(configData), 16'd0);
        checkOutput("rst_chain", 16'(chainId), 16'd0);
        checkOutput("rst_busy", 16'(busy), 16'd0);
        checkOutput("rst_done", 16'(done), 16'd0);
        checkOutput("rst_err", 16'(err), 16'd0);
        checkOutput("rst_ready", 16'(cmd_ready), 16'd1);
        reset = 1'b0;
        step(10);
        checkOutput("idle_tracing", 16'(tracing), 16'd1);
        checkOutput("idle_id", 16'(configId), 16'hFF);
        checkOutput("idle_busy", 16'(busy), 16'd0);
        checkOutput("idle_ready", 16'(cmd_ready), 16'd1);

        $display("[TB] single-entry batch");
        applyStimulus(1'b1, 8'd2, 2'd1, 8'h01, 1'b1);
        step(1);
        applyStimulus(1'b0, 8'h00, 2'd0, 8'h00, 1'b0);
        step(1 + LAT);
        checkOutput("one_e1_tracing", 16'(tracing), 16'd1);
        step(1);
        checkBeat("one_beat", 8'd2, 2'd1, 8'h01);
        checkOutput("one_beat_busy", 16'(busy), 16'd1);
        step(1);
        checkGuard("one_guard");
        step(1);
        checkDone("one_done");
        step(1);
        checkOutput("one_done_clear", 16'(done), 16'd0);

        $display("[TB] overflow without commit");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i), 2'(i), 8'(i), 1'b0);
            step(1);
        end
        applyStimulus(1'b0, 8'h00, 2'd0, 8'h00, 1'b0);
        checkOutput("ovf_ready", 16'(cmd_ready), 16'd0);
        step(2);
        checkOutput("ovf_err", 16'(err), 16'd1);
        checkOutput("ovf_tracing", 16'(tracing), 16'd1);
        checkOutput("ovf_id", 16'(configId), 16'hFF);
        pulseReset();
        checkOutput("ovf_err_cleared", 16'(err), 16'd0);
        checkOutput("ovf_ready_back", 16'(cmd_ready), 16'd1);

        $display("[TB] second batch queued during CONFIG");
        applyStimulus(1'b1, 8'h10, 2'd0, 8'hA1, 1'b0);
        step(1);
        applyStimulus(1'b1, 8'h11, 2'd1, 8'hA2, 1'b1);
        step(1);
        applyStimulus(1'b0, 8'h00, 2'd0, 8'h00, 1'b0);
        step(1 + LAT);
        applyStimulus(1'b1, 8'h12, 2'd2, 8'hB1, 1'b0);
        step(1);
        checkBeat("a_beat1", 8'h10, 2'd0, 8'hA1);
        applyStimulus(1'b1, 8'hFF, 2'd3, 8'hB2, 1'b1);
        step(1);
        checkBeat("a_beat2", 8'h11, 2'd1, 8'hA2);
        applyStimulus(1'b0, 8'h00, 2'd0, 8'h00, 1'b0);
        step(1);
        checkGuard("a_guard");
        step(1);
        checkDone("a_done");
        step(1 + LAT);
        checkBeat("b_beat1", 8'h12, 2'd2, 8'hB1);
        checkOutput("b_beat1_done", 16'(done), 16'd0);
        step(1);
        checkBeat("b_beat2", 8'hFF, 2'd3, 8'hB2);
        step(1);
        checkGuard("b_guard");
        step(1);
        checkDone("b_done");

        $display("[TB] reset in the middle of a batch");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h20 + i), 2'(i), 8'(8'hC0 + i), (i == 3));
            step(1);
        end
        applyStimulus(1'b0, 8'h00, 2'd0, 8'h00, 1'b0);
        step(2 + LAT);
        checkBeat("mid_beat1", 8'h20, 2'd0, 8'hC0);
        step(1);
        checkBeat("mid_beat2", 8'h21, 2'd1, 8'hC1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_tracing", 16'(tracing), 16'd1);
        checkOutput("mid_rst_id", 16'(configId), 16'hFF);
        checkOutput("mid_rst_busy", 16'(busy), 16'd0);
        step(1);
        reset = 1'b0;
        step(6 + LAT);
        checkOutput("mid_after_tracing", 16'(tracing), 16'd1);
        checkOutput("mid_after_id", 16'(configId), 16'hFF);
        checkOutput("mid_after_busy", 16'(busy), 16'd0);
        applyStimulus(1'b1, 8'h30, 2'd2, 8'h5A, 1'b1);
        step(1);
        applyStimulus(1'b0, 8'h00, 2'd0, 8'h00, 1'b0);
        step(2 + LAT);
        checkBeat("mid_fresh_beat", 8'h30, 2'd2, 8'h5A);
        step(2);
        checkDone("mid_fresh_done");

`ifdef CFG_DRAIN_EN
        $display("[TB] drain waits for quiet trace_valid");
        trace_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'h50 + i), 2'(i), 8'(8'hD0 + i), (i == 2));
            step(1);
        end
        applyStimulus(1'b0, 8'h00, 2'd0, 8'h00, 1'b0);
        step(2);
        trace_valid = 1'b0;
        step(3);
        checkOutput("drn_wait_tracing", 16'(tracing), 16'd1);
        checkOutput("drn_wait_busy", 16'(busy), 16'd1);
        step(1);
        checkOutput("drn_enter_tracing", 16'(tracing), 16'd1);
        step(1);
        checkBeat("drn_beat1", 8'h50, 2'd0, 8'hD0);
        step(1);
        checkBeat("drn_beat2", 8'h51, 2'd1, 8'hD1);
        step(1);
        checkBeat("drn_beat3", 8'h52, 2'd2, 8'hD2);
        step(1);
        checkGuard("drn_guard");
        step(1);
        checkDone("drn_done");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_config_sequencer.md
# trace_config_sequencer

Drives the reconfiguration side of the trace pipeline's building blocks, the reduce, filter and similar units that take `tracing`, `configId`, `configData` and `chainId`. It accepts firmware-write commands from the host or debug port over a valid/ready interface and buffers them in a small FIFO. When a complete batch is committed, it takes the pipeline out of tracing, replays the batch one beat per cycle, then returns the pipeline to tracing. It sits between the host config port and the broadcast config bus feeding every instrumentation block.

## Interface
- `MAX_CHAINS`, 4: chains per unit; `CHAIN_W = $clog2(MAX_CHAINS)`
- `FIFO_DEPTH`, 8: command entries buffered; power of two, ≥ 2
- `DRAIN_CYCLES`, 4: consecutive quiet cycles required before leaving tracing (used only with `CFG_DRAIN_EN`)
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted this cycle when high with `cmd_valid`
- `cmd_config_id`  in  8  target unit ID
- `cmd_chain`  in  CHAIN_W  target firmware slot
- `cmd_data`  in  8  firmware byte
- `cmd_last`  in  1  final command of a batch; commits the batch
- `trace_valid`  in  1  OR of `valid_in` entering the trace pipeline
- `tracing`  out  1  high = normal tracing; low = units accept config
- `configId`  out  8  broadcast target ID; `8'hFF` when no beat
- `configData`  out  8  broadcast firmware byte
- `chainId`  out  CHAIN_W  broadcast firmware slot
- `busy`  out  1  high outside TRACE state
- `done`  out  1  one-cycle pulse on return to tracing
- `err`  out  1  sticky: FIFO full with no committed batch

## Operation
- FIFO entry is {config_id, chain, data, last}. `cmd_ready = !full`. Push and pop may occur in the same cycle; occupancy is unchanged.
- `pending` counts committed batches in the FIFO. It increments on acceptance of a `cmd_last` entry and decrements on pop of a `last` entry. Simultaneous increment and decrement leave it unchanged.
- FSM states:
  - TRACE: `tracing=1`, `configId=8'hFF`. If `pending>0`, go to DRAIN (macro on) or CONFIG (macro off).
  - DRAIN: `tracing=1`. The quiet counter clears on `trace_valid=1` and increments otherwise. When the count reaches `DRAIN_CYCLES`, go to CONFIG.
  - CONFIG: pop one entry per cycle and register it onto `configId`/`chainId`/`configData` with `tracing=0`. Popping an entry with `last=1` moves to RESUME.
  - RESUME: one guard cycle with `tracing=0`, `configId=8'hFF`, `configData=0`. Then TRACE, with `done=1` for the first TRACE cycle.
- `configId=8'hFF` is reserved: no unit may use ID 255. A command carrying `8'hFF` is forwarded unchanged and is a no-op.
- Batches longer than `FIFO_DEPTH` are illegal. If `full && pending==0`, set `err`; it is cleared only by `reset`.
- Commands arriving during DRAIN/CONFIG are accepted. They form the next batch; a batch committed during CONFIG runs in a later pass.

## Timing
- All outputs are registered. Reset values: `tracing=1`, `configId=8'hFF`, `configData=0`, `chainId=0`, `busy=0`, `done=0`, `err=0`, `cmd_ready=1`. FIFO empty, `pending=0`, state TRACE.
- Macro off: a `cmd_last` accepted at edge E0 makes `pending=1` after E0. The FSM enters CONFIG at E1. The first beat and `tracing=0` appear at E2, and later beats follow one per edge.
- A batch of k entries: last beat at E(k+1), guard at E(k+2), `tracing=1` and `done=1` at E(k+3).
- Macro on: CONFIG is entered `DRAIN_CYCLES` quiet edges after DRAIN entry. Any `trace_valid` restarts the count.
- `reset` asserted mid-CONFIG forces the reset values immediately and discards the partial batch.

## Configuration
- `CFG_DRAIN_EN`: when defined, the DRAIN state and quiet counter are compiled in. When undefined, TRACE goes directly to CONFIG, `trace_valid` is ignored, and `DRAIN_CYCLES` is unused.

## Structure
- Package `trace_cfg_pkg`: state enum (TRACE, DRAIN, CONFIG, RESUME), `CFG_IDLE_ID = 8'hFF`, packed entry struct typedef.
- Sub-module `cfg_fifo`: synchronous FIFO with full/empty flags, parameterised on depth and entry type.

## Test plan
- Reset, then idle 10 cycles -> `tracing=1`, `configId=8'hFF`, `busy=0`, `cmd_ready=1`.
- Macro off; push {id 2, chain 1, data 8'h01, last} -> beat id 2/chain 1/data 8'h01 with `tracing=0` at E2, guard at E3, `tracing=1` and `done=1` at E4.
- Macro on, `DRAIN_CYCLES=4`; commit a 3-entry batch with `trace_valid` high for 2 more cycles -> CONFIG entered 4 edges after the last `trace_valid`, 3 consecutive beats in order.
- Push 8 entries with no `last` -> `cmd_ready=0`, `err=1`, `tracing` stays 1.
- Commit a batch of 2, then push a second batch during CONFIG -> two separate passes, each ending with its own guard cycle and `done` pulse.
- Assert `reset` on the second beat of a 4-entry batch -> `tracing=1` and `configId=8'hFF` immediately, FIFO empty, no further beats.
